// File: rtl/rbm_pkg.sv
// Shared fixed-point types, accumulator limits and FSM state codes for the
// RBM contrastive-divergence datapath.
package rbm_pkg;

   localparam int ACC_W      = 32;
   localparam int ACC_FRAC   = 23;
   localparam int PROD_SHIFT = 7;

   typedef logic signed [15:0]      q1_15_t;
   typedef logic signed [ACC_W-1:0] q7_23_t;
   typedef logic signed [31:0]      q2_30_t;

   localparam q7_23_t SAT_MAX = 32'sh7FFF_FFFF;
   localparam q7_23_t SAT_MIN = 32'sh8000_0000;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_CLEAR  = 3'd1;
   localparam state_t S_LOAD_V = 3'd2;
   localparam state_t S_SWEEP  = 3'd3;
   localparam state_t S_DRAIN  = 3'd4;
   localparam state_t S_DONE   = 3'd5;

   typedef struct packed {
      q7_23_t sum;
      logic   sat;
   } sat_res_t;

   // Overflow shows up as disagreement between the guard bit and the sign bit.
   function automatic sat_res_t sat_add(input q7_23_t a, input q7_23_t b);
      logic signed [ACC_W:0] s;
      sat_res_t r;
      s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      r.sat = (s[ACC_W] != s[ACC_W-1]);
      if (!r.sat) r.sum = s[ACC_W-1:0];
      else        r.sum = s[ACC_W] ? SAT_MIN : SAT_MAX;
      return r;
   endfunction

endpackage

// File: rtl/acc_mac_pipe.sv
// Two-stage multiply / saturating-accumulate pipe: stage 1 registers v*h,
// stage 2 adds the scaled product to the returned BRAM word and issues the write.
module acc_mac_pipe
   import rbm_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  q1_15_t        v,
   input  q1_15_t        h,
   input  logic [AW-1:0] addr,
   input  logic          phase,
   input  q7_23_t        rd_data,
   output logic          pending,
   output logic [AW-1:0] wr_addr,
   output q7_23_t        wr_data,
   output logic [1:0]    wr_we,
   output logic          sat
);

   q2_30_t        prod_q;
   logic [AW-1:0] addr1_q;
   logic          phase1_q;
   logic          valid1_q;
   q7_23_t        inc;
   sat_res_t      res;

   assign inc     = prod_q >>> PROD_SHIFT;
   assign res     = sat_add(rd_data, inc);
   assign pending = valid1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q   <= '0;
         addr1_q  <= '0;
         phase1_q <= 1'b0;
         valid1_q <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_we    <= 2'b00;
         sat      <= 1'b0;
      end else begin
         prod_q   <= q2_30_t'(v) * q2_30_t'(h);
         addr1_q  <= addr;
         phase1_q <= phase;
         valid1_q <= in_valid;
         wr_addr  <= addr1_q;
         wr_data  <= res.sum;
         wr_we    <= valid1_q ? (phase1_q ? 2'b10 : 2'b01) : 2'b00;
         sat      <= valid1_q & res.sat;
      end
   end

endmodule

// File: rtl/cd_stat_accum.sv
// CD statistics accumulator: owns clear, v/h stream intake and address
// generation for the acc_pos/acc_neg read-modify-write sweep.
module cd_stat_accum
   import rbm_pkg::*;
#(
   parameter int unsigned I_TILE = 64,
   parameter int unsigned H_TILE = 64,
   parameter int unsigned AW     = $clog2(I_TILE * H_TILE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          v_valid,
   output logic          v_ready,
   input  logic [15:0]   v_data,
   input  logic          v_phase,
   input  logic          h_valid,
   output logic          h_ready,
   input  logic [15:0]   h_data,
   input  logic          h_last,
   output logic [AW-1:0] acc_rd_addr,
   output logic          acc_rd_bank,
   input  logic [31:0]   acc_rd_data,
   output logic [AW-1:0] acc_wr_addr,
   output logic [31:0]   acc_wr_data,
   output logic [1:0]    acc_wr_we,
   output logic          busy,
   output logic          done,
   output logic          sat_flag
);

   localparam int unsigned IW = $clog2(I_TILE);
   localparam int unsigned HW = (H_TILE > 1) ? $clog2(H_TILE) : 1;

   state_t        state_q;
   logic [AW-1:0] k_q;
   logic [IW-1:0] vi_q;
   logic [IW-1:0] ri_q;
   logic [HW-1:0] hi_q;
   logic          row_active_q;
   q1_15_t        h_q;
   logic          hlast_q;
   logic          phase_q;
   logic          sat_flag_q;
   q1_15_t        v_rf [I_TILE];

   logic          mac_pending;
   logic [AW-1:0] mac_wr_addr;
   q7_23_t        mac_wr_data;
   logic [1:0]    mac_wr_we;
   logic          mac_sat;
   logic          clearing;

   assign acc_rd_addr = AW'(hi_q) * AW'(I_TILE) + AW'(ri_q);
   assign acc_rd_bank = phase_q;
   assign v_ready     = (state_q == S_LOAD_V);
   assign h_ready     = (state_q == S_SWEEP) && !row_active_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign sat_flag    = sat_flag_q;

   // Clear writes bypass the MAC pipe, which is always empty during CLEAR.
   assign clearing    = (state_q == S_CLEAR);
   assign acc_wr_addr = clearing ? k_q : mac_wr_addr;
   assign acc_wr_data = clearing ? 32'h0 : mac_wr_data;
   assign acc_wr_we   = clearing ? 2'b11 : mac_wr_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         vi_q         <= '0;
         ri_q         <= '0;
         hi_q         <= '0;
         row_active_q <= 1'b0;
         h_q          <= '0;
         hlast_q      <= 1'b0;
         phase_q      <= 1'b0;
         sat_flag_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clear) begin
                  state_q    <= S_CLEAR;
                  k_q        <= '0;
                  sat_flag_q <= 1'b0;
               end else if (v_valid) begin
                  state_q <= S_LOAD_V;
               end
            end
            S_CLEAR: begin
               k_q <= k_q + 1'b1;
               if (k_q == AW'(I_TILE * H_TILE - 1)) state_q <= S_DONE;
            end
            S_LOAD_V: begin
               if (v_valid) begin
                  if (vi_q == '0) phase_q <= v_phase;
                  if (vi_q == IW'(I_TILE - 1)) begin
                     vi_q    <= '0;
                     hi_q    <= '0;
                     state_q <= S_SWEEP;
                  end else begin
                     vi_q <= vi_q + 1'b1;
                  end
               end
            end
            S_SWEEP: begin
               if (!row_active_q) begin
                  if (h_valid) begin
                     h_q          <= h_data;
                     hlast_q      <= h_last;
                     row_active_q <= 1'b1;
                     ri_q         <= '0;
                  end
               end else if (ri_q == IW'(I_TILE - 1)) begin
                  row_active_q <= 1'b0;
                  ri_q         <= '0;
                  if (hi_q == HW'(H_TILE - 1)) begin
                     hi_q    <= '0;
                     state_q <= hlast_q ? S_DRAIN : S_LOAD_V;
                  end else begin
                     hi_q <= hi_q + 1'b1;
                  end
               end else begin
                  ri_q <= ri_q + 1'b1;
               end
            end
            // Once stage 1 is empty the last write is on the bus this cycle.
            S_DRAIN: if (!mac_pending) state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         if (mac_sat) sat_flag_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_LOAD_V && v_valid) v_rf[vi_q] <= v_data;
   end

   acc_mac_pipe #(
      .AW(AW)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .in_valid((state_q == S_SWEEP) && row_active_q),
      .v       (v_rf[ri_q]),
      .h       (h_q),
      .addr    (acc_rd_addr),
      .phase   (phase_q),
      .rd_data (acc_rd_data),
      .pending (mac_pending),
      .wr_addr (mac_wr_addr),
      .wr_data (mac_wr_data),
      .wr_we   (mac_wr_we),
      .sat     (mac_sat)
   );

endmodule

// File: tb/tb_cd_stat_accum.sv
// Scoreboard bench for cd_stat_accum with a 4x4 tile and a behavioural
// two-bank BRAM with one-cycle read latency.
module tb_cd_stat_accum;

   localparam int I  = 4;
   localparam int H  = 4;
   localparam int N  = I * H;
   localparam int AW = 4;

   typedef logic [15:0] vec_t [4];
   typedef struct packed {
      logic [1:0]  we;
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic          clk, rst, clear;
   logic          v_valid, v_ready, v_phase;
   logic [15:0]   v_data;
   logic          h_valid, h_ready, h_last;
   logic [15:0]   h_data;
   logic [AW-1:0] acc_rd_addr, acc_wr_addr;
   logic          acc_rd_bank;
   logic [31:0]   acc_rd_data, acc_wr_data;
   logic [1:0]    acc_wr_we;
   logic          busy, done, sat_flag;

   cd_stat_accum #(
      .I_TILE(I),
      .H_TILE(H),
      .AW    (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .v_valid    (v_valid),
      .v_ready    (v_ready),
      .v_data     (v_data),
      .v_phase    (v_phase),
      .h_valid    (h_valid),
      .h_ready    (h_ready),
      .h_data     (h_data),
      .h_last     (h_last),
      .acc_rd_addr(acc_rd_addr),
      .acc_rd_bank(acc_rd_bank),
      .acc_rd_data(acc_rd_data),
      .acc_wr_addr(acc_wr_addr),
      .acc_wr_data(acc_wr_data),
      .acc_wr_we  (acc_wr_we),
      .busy       (busy),
      .done       (done),
      .sat_flag   (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM banks
   logic [31:0] pos_mem [N];
   logic [31:0] neg_mem [N];
   logic        pre_en;
   logic [31:0] pre_val;

   always @(posedge clk) begin
      if (pre_en) begin
         for (int a = 0; a < N; a++) begin
            pos_mem[a] <= pre_val;
            neg_mem[a] <= pre_val;
         end
      end else begin
         if (acc_wr_we[0]) pos_mem[acc_wr_addr] <= acc_wr_data;
         if (acc_wr_we[1]) neg_mem[acc_wr_addr] <= acc_wr_data;
      end
      acc_rd_data <= acc_rd_bank ? neg_mem[acc_rd_addr] : pos_mem[acc_rd_addr];
   end

   logic [31:0] ref_pos [N];
   logic [31:0] ref_neg [N];
   wr_t         exp_q [$];
   wr_t         e;
   int          checks, failures, done_cnt;
   logic        sb_ignore;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected write per observed write cycle
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (!rst && !sb_ignore && acc_wr_we != 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got we=%b addr=%0d data=%h expected none",
                     acc_wr_we, acc_wr_addr, acc_wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_we", {30'b0, acc_wr_we}, {30'b0, e.we});
            check("wr_addr", {28'b0, acc_wr_addr}, {28'b0, e.addr});
            check("wr_data", acc_wr_data, e.data);
         end
      end
   end

   function automatic logic [31:0] model_acc(input logic [31:0] old, input logic [15:0] v,
                                            input logic [15:0] h);
      logic signed [31:0] p, inc;
      logic signed [32:0] s;
      p   = $signed(v) * $signed(h);
      inc = p >>> 7;
      s   = $signed({old[31], old}) + $signed({inc[31], inc});
      if (s > 33'sd2147483647)       return 32'h7FFF_FFFF;
      else if (s < -33'sd2147483648) return 32'h8000_0000;
      else                           return s[31:0];
   endfunction

   task automatic push_wr(input logic [1:0] we, input int a, input logic [31:0] d);
      exp_q.push_back(wr_t'{we: we, addr: 4'(a), data: d});
      if (we[0]) ref_pos[a] = d;
      if (we[1]) ref_neg[a] = d;
   endtask

   task automatic push_const(input logic [1:0] we, input logic [31:0] d);
      for (int a = 0; a < N; a++) push_wr(we, a, d);
   endtask

   task automatic push_model(input vec_t v, input vec_t h, input logic ph);
      for (int hh = 0; hh < H; hh++)
         for (int ii = 0; ii < I; ii++) begin
            int a;
            a = hh * I + ii;
            push_wr(ph ? 2'b10 : 2'b01, a,
                    model_acc(ph ? ref_neg[a] : ref_pos[a], v[ii], h[hh]));
         end
   endtask

   task automatic gap(input bit en);
      if (en) repeat ($urandom_range(0, 3)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_v(input vec_t v, input logic ph, input bit gaps);
      for (int i = 0; i < I; i++) begin
         int n;
         gap(gaps);
         v_valid = 1'b1;
         v_data  = v[i];
         v_phase = ph;
         n = 0;
         @(negedge clk);
         while (!v_ready && n < 500) begin
            @(negedge clk);
            n++;
         end
         check("v_handshake", {31'b0, v_ready}, 32'd1);
         @(posedge clk);
         #1;
         v_valid = 1'b0;
      end
   endtask

   task automatic send_h_word(input logic [15:0] d, input logic last);
      int n;
      h_valid = 1'b1;
      h_data  = d;
      h_last  = last;
      n = 0;
      @(negedge clk);
      while (!h_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("h_handshake", {31'b0, h_ready}, 32'd1);
      @(posedge clk);
      #1;
      h_valid = 1'b0;
      h_last  = 1'b0;
   endtask

   task automatic send_h(input vec_t h, input logic last, input bit gaps);
      for (int i = 0; i < H; i++) begin
         gap(gaps);
         send_h_word(h[i], last && (i == H - 1));
      end
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, done}, 32'd1);
      repeat (3) @(negedge clk);
      check({name, "_count"}, done_cnt, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      done_cnt = 0;
      push_const(2'b11, 32'h0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      wait_done("clear_done");
      check("sat_after_clear", {31'b0, sat_flag}, 32'd0);
   endtask

   task automatic run_one(input vec_t v, input vec_t h, input logic ph);
      done_cnt = 0;
      send_v(v, ph, 1'b0);
      send_h(h, 1'b1, 1'b0);
      wait_done("batch_done");
   endtask

   task automatic preload(input logic [31:0] val);
      pre_val = val;
      pre_en  = 1'b1;
      for (int a = 0; a < N; a++) begin
         ref_pos[a] = val;
         ref_neg[a] = val;
      end
      @(posedge clk);
      #1;
      pre_en = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   vec_t q_half, q_neg1, s0v, s0h, s1v, s1h, s2v, s2h;

   initial begin
      checks = 0; failures = 0; done_cnt = 0; sb_ignore = 1'b0;
      rst = 1'b1; clear = 1'b0;
      v_valid = 1'b0; v_data = '0; v_phase = 1'b0;
      h_valid = 1'b0; h_data = '0; h_last = 1'b0;
      pre_en = 1'b1; pre_val = '0;
      q_half = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
      q_neg1 = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
      s0v = '{16'h4000, 16'hC000, 16'h2000, 16'h7FFF};
      s0h = '{16'h4000, 16'h1000, 16'h8000, 16'hF000};
      s1v = '{16'h8000, 16'h0100, 16'h6000, 16'hA000};
      s1h = '{16'h7FFF, 16'h8000, 16'h3000, 16'h0800};
      s2v = '{16'h1234, 16'hFEDC, 16'h4000, 16'h8000};
      s2h = '{16'h2000, 16'hE000, 16'h7FFF, 16'h4000};
      for (int a = 0; a < N; a++) begin
         ref_pos[a] = '0;
         ref_neg[a] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      pre_en = 1'b0;
      check("rst_v_ready", {31'b0, v_ready}, 32'd0);
      check("rst_h_ready", {31'b0, h_ready}, 32'd0);
      check("rst_wr_we", {30'b0, acc_wr_we}, 32'd0);
      check("rst_rd_addr", {28'b0, acc_rd_addr}, 32'd0);
      check("rst_wr_addr", {28'b0, acc_wr_addr}, 32'd0);
      check("rst_wr_data", acc_wr_data, 32'd0);
      check("rst_rd_bank", {31'b0, acc_rd_bank}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_sat", {31'b0, sat_flag}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_clear();
      push_const(2'b01, 32'h0020_0000);
      run_one(q_half, q_half, 1'b0);

      do_clear();
      push_const(2'b10, 32'h0080_0000);
      run_one(q_neg1, q_neg1, 1'b1);

      do_clear();
      push_const(2'b10, 32'hFFC0_0000);
      run_one(q_neg1, q_half, 1'b1);

      // Saturation and stickiness
      preload(32'h7FFF_FF00);
      push_const(2'b01, 32'h7FFF_FFFF);
      run_one(q_half, q_half, 1'b0);
      check("sat_set", {31'b0, sat_flag}, 32'd1);
      push_const(2'b01, 32'h7FBF_FFFF);
      run_one(q_neg1, q_half, 1'b0);
      check("sat_sticky", {31'b0, sat_flag}, 32'd1);
      do_clear();

      // Three samples with stream gaps, h_last on the third
      done_cnt = 0;
      push_model(s0v, s0h, 1'b0);
      send_v(s0v, 1'b0, 1'b1);
      send_h(s0h, 1'b0, 1'b1);
      push_model(s1v, s1h, 1'b1);
      send_v(s1v, 1'b1, 1'b1);
      send_h(s1h, 1'b0, 1'b1);
      push_model(s2v, s2h, 1'b0);
      send_v(s2v, 1'b0, 1'b1);
      send_h(s2h, 1'b1, 1'b1);
      wait_done("multi_done");
      for (int a = 0; a < N; a++) begin
         check("bank_pos", pos_mem[a], ref_pos[a]);
         check("bank_neg", neg_mem[a], ref_neg[a]);
      end

      // Reset in the middle of a row
      sb_ignore = 1'b1;
      send_v(q_half, 1'b0, 1'b0);
      send_h_word(16'h4000, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_wr_we", {30'b0, acc_wr_we}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_v_ready", {31'b0, v_ready}, 32'd0);
      check("midrst_h_ready", {31'b0, h_ready}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb_ignore = 1'b0;
      do_clear();
      push_const(2'b01, 32'h0020_0000);
      run_one(q_half, q_half, 1'b0);

      repeat (4) @(posedge clk);
      check("sb_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
